fft_bitrev_reorder: RTL and testbench

- Output-side reorder buffer for the 64-point FFT datapath.
- The butterfly pipeline emits each frame's complex samples in bit-reversed bin order. This block writes them into a double-buffered (ping-pong) RAM at bit-reversed addresses and reads them out in natural bin order, 0..N-1.
- It sits directly after the last butterfly/twiddle stage and feeds downstream consumers.

---
 rtl/fft_bitrev_reorder_if.sv | 42 ++++
 rtl/fft_bitrev_reorder.sv | 160 ++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// ============================================================================
// Module      : fft_bitrev_reorder_if
// Description : Sample stream bundle for the FFT bit-reverse reorder buffer.
//               Optional do_idx field is present when FFT_BITREV_INDEX_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
);
  logic                    di_en;
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic                    do_en;
  logic signed [WIDTH-1:0] do_re;
  logic signed [WIDTH-1:0] do_im;
  logic                    do_first;
`ifdef FFT_BITREV_INDEX_EN
  logic [LOG2N-1:0]        do_idx;
`endif

  // master: upstream producer / downstream consumer side; slave: the reorder block
  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_re, do_im, do_first
`ifdef FFT_BITREV_INDEX_EN
    , input do_idx
`endif
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_re, do_im, do_first
`ifdef FFT_BITREV_INDEX_EN
    , output do_idx
`endif
  );
endinterface

`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
// ============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong reorder buffer: bit-reversed frame in, natural order out.
//               Optional bin-index output enabled by macro FFT_BITREV_INDEX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  fft_bitrev_reorder_if.slave bus
);

  localparam int               c_n    = 1 << LOG2N;
  localparam logic [LOG2N-1:0] c_last = LOG2N'(c_n - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // bank in the MSB, entry in the LSBs
  logic [2*WIDTH-1:0] r_mem [0:2*c_n-1];

  logic [LOG2N-1:0]   r_wcnt;
  logic               r_wbank;
  logic [LOG2N-1:0]   w_waddr;
  logic               w_frame_done;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LOG2N-1:0]   r_rcnt;
  logic [LOG2N-1:0]   w_rcnt_nxt;
  logic               r_rbank;
  logic               w_rbank_nxt;
  logic               r_pend;
  logic               w_pend_nxt;
  logic               w_rd;

  logic               r_do_en;
  logic               r_do_first;
  logic [2*WIDTH-1:0] r_do_data;

  for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
    assign w_waddr[i] = r_wcnt[LOG2N-1-i];
  end

  assign w_frame_done = bus.di_en && (r_wcnt == c_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
    end else if (bus.di_en) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_frame_done) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (bus.di_en) begin
      r_mem[{r_wbank, w_waddr}] <= {bus.di_re, bus.di_im};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_rbank <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rbank <= w_rbank_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // A frame that completes while a readout is running is queued in r_pend and
  // picked up on the other bank right after the last entry, without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rbank_nxt = r_rbank;
    w_pend_nxt  = r_pend;
    w_rd        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_frame_done) begin
          w_state_nxt = READ;
          w_rbank_nxt = r_wbank;
          w_rcnt_nxt  = '0;
        end
      end
      READ: begin
        w_rd       = 1'b1;
        w_rcnt_nxt = r_rcnt + 1'b1;
        if (w_frame_done) begin
          w_pend_nxt = 1'b1;
        end
        if (r_rcnt == c_last) begin
          if (w_frame_done || r_pend) begin
            w_rbank_nxt = ~r_rbank;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_do_en    <= 1'b0;
      r_do_first <= 1'b0;
      r_do_data  <= '0;
    end else begin
      r_do_en    <= w_rd;
      r_do_first <= w_rd && (r_rcnt == '0);
      if (w_rd) begin
        r_do_data <= r_mem[{r_rbank, r_rcnt}];
      end
    end
  end

  assign bus.do_en    = r_do_en;
  assign bus.do_first = r_do_first;
  assign bus.do_re    = r_do_data[2*WIDTH-1:WIDTH];
  assign bus.do_im    = r_do_data[WIDTH-1:0];

`ifdef FFT_BITREV_INDEX_EN
  logic [LOG2N-1:0] r_do_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_do_idx <= '0;
    end else if (w_rd) begin
      r_do_idx <= r_rcnt;
    end
  end

  assign bus.do_idx = r_do_idx;
`else
  // index output not built
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
// ============================================================================
// Module      : tb_fft_bitrev_reorder
// Description : Self-checking bench for fft_bitrev_reorder (queue-based frame model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_bitrev_reorder;
  localparam int WIDTH = 16;
  localparam int LOG2N = 6;
  localparam int N     = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  fft_bitrev_reorder_if #(.WIDTH(WIDTH), .LOG2N(LOG2N)) bus ();

  fft_bitrev_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               first;
    int                 n;
    int                 at;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q[$];
  logic signed [15:0] fre [N];
  logic signed [15:0] fim [N];
  int   pos      = 0;
  int   last_end = -1000;
  int   last_done = 0;
  int   fcyc[$];
  logic signed [15:0] fval[$];
  int   run = 0;
  int   run_max = 0;
  int   ca;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int bitrev(int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (v[i]) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one input slot; the model completes a frame when position N-1 lands.
  task automatic sample(logic v, logic signed [15:0] re, logic signed [15:0] im);
    int start;
    @(posedge clock);
    #1;
    bus.di_en = v;
    bus.di_re = re;
    bus.di_im = im;
    if (v) begin
      fre[pos] = re;
      fim[pos] = im;
      if (pos == N - 1) begin
        start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
        for (int n = 0; n < N; n++)
          q.push_back('{fre[bitrev(n)], fim[bitrev(n)], (n == 0), n, start + n});
        last_end  = start + N - 1;
        last_done = cyc;
        pos = 0;
      end else begin
        pos++;
      end
    end
  endtask

  task automatic drain();
    @(posedge clock);
    #1 bus.di_en = 1'b0;
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clock);
    chk("drain_queue_empty", q.size(), 0);
    repeat (3) @(posedge clock);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.do_en) begin
        run++;
        if (run > run_max) run_max = run;
        if (bus.do_first) begin
          fcyc.push_back(cyc);
          fval.push_back(bus.do_re);
        end
      end else begin
        run = 0;
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        chk("do_en", bus.do_en, 1);
        chk("do_re", bus.do_re, q[0].re);
        chk("do_im", bus.do_im, q[0].im);
        chk("do_first", bus.do_first, q[0].first);
`ifdef FFT_BITREV_INDEX_EN
        chk("do_idx", bus.do_idx, q[0].n);
`endif
        void'(q.pop_front());
      end else begin
        chk("do_en_idle", bus.do_en, 0);
      end
    end
  end

  initial begin
    bus.di_en = 1'b0;
    bus.di_re = '0;
    bus.di_im = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_do_en", bus.do_en, 0);
    chk("rst_do_first", bus.do_first, 0);
    chk("rst_do_re", bus.do_re, 0);
    chk("rst_do_im", bus.do_im, 0);
`ifdef FFT_BITREV_INDEX_EN
    chk("rst_do_idx", bus.do_idx, 0);
`endif
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;

    // single continuous frame
    for (int k = 0; k < N; k++) sample(1'b1, 16'(k), 16'(-k));
    chk("model_bin0_re", q[0].re, 0);
    chk("model_bin0_first", q[0].first, 1);
    chk("model_bin1_re", q[1].re, 32);
    chk("model_bin32_re", q[32].re, 1);
    chk("model_bin32_im", q[32].im, -1);
    chk("model_bin0_at", q[0].at, last_done + 2);
    drain();

    // gapped frame
    for (int k = 0; k < N; k++) begin
      sample(1'b1, 16'(k), 16'(-k));
      sample(1'b0, 16'h0, 16'h0);
    end
    drain();

    // back-to-back frames
    fcyc.delete();
    fval.delete();
    run_max = 0;
    for (int k = 0; k < N; k++) sample(1'b1, 16'(k), 16'h0);
    ca = last_done;
    for (int k = 0; k < N; k++) sample(1'b1, 16'(100 + k), 16'h0);
    drain();
    chk("b2b_first_count", fcyc.size(), 2);
    if (fcyc.size() >= 2) begin
      chk("b2b_a_start", fcyc[0], ca + 2);
      chk("b2b_b_start", fcyc[1], ca + 66);
      chk("b2b_b_first_re", fval[1], 100);
    end
    chk("b2b_run_len", run_max, 128);

    // extreme values
    for (int k = 0; k < N; k++)
      sample(1'b1, k[0] ? 16'sh8000 : 16'sh7FFF, 16'sh8000);
    chk("model_ext_bin0", q[0].re, 32'h0000_7FFF);
    chk("model_ext_bin32", q[32].re, 32'hFFFF_8000);
    drain();

    // reset in the middle of a frame
    for (int k = 0; k < 30; k++) sample(1'b1, 16'(500 + k), 16'(k));
    @(posedge clock);
    #1 bus.di_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_do_en", bus.do_en, 0);
    chk("midrst_do_re", bus.do_re, 0);
    chk("midrst_do_im", bus.do_im, 0);
`ifdef FFT_BITREV_INDEX_EN
    chk("midrst_do_idx", bus.do_idx, 0);
`endif
    q.delete();
    pos = 0;
    last_end = -1000;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    for (int k = 0; k < N; k++) sample(1'b1, 16'(200 + k), 16'(k));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
